sync_fifo: RTL and testbench

- Single-clock, first-in-first-out buffer for narrow data words (default 4 bits, 8 entries).
- Decouples a producer and a consumer in the same clock domain.
- Provides registered read data and combinational full/empty status flags.
- Write and read sides have separate clock ports, but both are driven by the same clock; no clock-domain-crossing logic exists.

---
 rtl/sync_fifo.sv | 86 ++++++++
 tb/tb_sync_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and combinational full/empty flags.
// Write-side state is clocked by w_clk, read-side state by r_clk; both must share one clock net.
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  w_clk,
  input  logic                  r_clk,
  input  logic                  reset,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH:0]    wptr_reg;
  logic [PTR_WIDTH:0]    wptr_next;
  logic [PTR_WIDTH:0]    rptr_reg;
  logic [PTR_WIDTH:0]    rptr_next;
  logic [DATA_WIDTH-1:0] dout_reg;

  logic                  wr_fire;
  logic                  rd_fire;
  logic [PTR_WIDTH-1:0]  waddr;
  logic [PTR_WIDTH-1:0]  raddr;

  assign waddr = wptr_reg[PTR_WIDTH-1:0];
  assign raddr = rptr_reg[PTR_WIDTH-1:0];

  // The wrap bit tells full (MSBs differ) apart from empty (pointers identical).
  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[PTR_WIDTH] != rptr_reg[PTR_WIDTH]) &&
                 (waddr == raddr);

  // Flags are sampled before the edge, so a read on empty or a write on full is refused.
  assign wr_fire = w_en && !full;
  assign rd_fire = r_en && !empty;

  always_comb begin
    wptr_next = wptr_reg;
    rptr_next = rptr_reg;
    if (wr_fire) begin
      wptr_next = wptr_reg + PTR_ONE;
    end
    if (rd_fire) begin
      rptr_next = rptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      wptr_reg <= '0;
    end else begin
      wptr_reg <= wptr_next;
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge w_clk) begin
    if (wr_fire) begin
      mem[waddr] <= din;
    end
  end

  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      rptr_reg <= '0;
      dout_reg <= '0;
    end else begin
      rptr_reg <= rptr_next;
      if (rd_fire) begin
        dout_reg <= mem[raddr];
      end
    end
  end

  assign dout = dout_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and model-checked stimulus for sync_fifo (4-bit x 8 entries).
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       w_en;
  logic [3:0] din;
  logic       r_en;
  logic [3:0] dout;
  logic       empty;
  logic       full;

  int checks   = 0;
  int failures = 0;
  logic [3:0] q[$];

  sync_fifo #(.DATA_WIDTH(4), .DEPTH(8)) dut (
    .w_clk (clk),
    .r_clk (clk),
    .reset (reset),
    .w_en  (w_en),
    .din   (din),
    .r_en  (r_en),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic we, input logic [3:0] d, input logic re);
    w_en = we;
    din  = d;
    r_en = re;
    step();
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic flags(input string tag, input logic e, input logic f);
    check({tag, "_empty"}, {7'd0, empty}, {7'd0, e});
    check({tag, "_full"},  {7'd0, full},  {7'd0, f});
  endtask

  initial begin
    logic we;
    logic re;
    logic [3:0] d;
    logic [3:0] exp_d;

    reset = 1'b0;
    w_en  = 1'b0;
    r_en  = 1'b0;
    din   = 4'h0;
    #2 reset = 1'b1;

    // Reset held for 5 cycles
    repeat (5) step();
    flags("rst_held", 1'b1, 1'b0);
    check("rst_held_dout", {4'd0, dout}, 8'h0);
    reset = 1'b0;
    step();
    flags("rst_rel", 1'b1, 1'b0);
    check("rst_rel_dout", {4'd0, dout}, 8'h0);

    // Fill with 1..8, then a dropped 9th write of 0xF
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 4'(i), 1'b0);
      if (i == 7) flags("fill7", 1'b0, 1'b0);
    end
    flags("fill8", 1'b0, 1'b1);
    cyc(1'b1, 4'hF, 1'b0);
    flags("fill9_drop", 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      check($sformatf("drain%0d", i), {4'd0, dout}, 8'(i));
      if (i == 1) flags("drain1", 1'b0, 1'b0);
    end
    flags("drained", 1'b1, 1'b0);

    // Reads on empty are refused and dout holds
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      check($sformatf("empty_rd%0d_dout", i), {4'd0, dout}, 8'h8);
      check($sformatf("empty_rd%0d_empty", i), {7'd0, empty}, 8'h1);
    end
    cyc(1'b1, 4'hA, 1'b0);
    flags("wr_A", 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    check("rd_A", {4'd0, dout}, 8'hA);
    flags("rd_A", 1'b1, 1'b0);

    // Simultaneous write+read with two entries stored
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'h4, 1'b0);
    cyc(1'b1, 4'h5, 1'b1);
    check("simul_dout", {4'd0, dout}, 8'h3);
    flags("simul", 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    check("simul_rd4", {4'd0, dout}, 8'h4);
    flags("simul_rd4", 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    check("simul_rd5", {4'd0, dout}, 8'h5);
    flags("simul_rd5", 1'b1, 1'b0);

    // Simultaneous on empty: only the write happens
    cyc(1'b1, 4'hC, 1'b1);
    check("simul_empty_dout", {4'd0, dout}, 8'h5);
    flags("simul_empty", 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    check("simul_empty_rdC", {4'd0, dout}, 8'hC);

    // Simultaneous on full: only the read happens
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(8 - i), 1'b0);
    flags("refill", 1'b0, 1'b1);
    cyc(1'b1, 4'hE, 1'b1);
    check("simul_full_dout", {4'd0, dout}, 8'h8);
    flags("simul_full", 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      check($sformatf("simul_full_drain%0d", i), {4'd0, dout}, 8'(8 - i));
    end
    flags("simul_full_drained", 1'b1, 1'b0);

    // Random traffic against a queue model
    q.delete();
    for (int n = 0; n < 50; n++) begin
      we = ($urandom_range(0, 99) < 60) && (q.size() < 8);
      re = ($urandom_range(0, 99) < 50) && (q.size() > 0);
      d  = 4'($urandom_range(0, 15));
      exp_d = 4'h0;
      if (re) exp_d = q.pop_front();
      if (we) q.push_back(d);
      cyc(we, d, re);
      if (re) check($sformatf("rand%0d_dout", n), {4'd0, dout}, {4'd0, exp_d});
      check($sformatf("rand%0d_empty", n), {7'd0, empty}, {7'd0, q.size() == 0});
      check($sformatf("rand%0d_full", n),  {7'd0, full},  {7'd0, q.size() == 8});
    end
    while (q.size() > 0) begin
      exp_d = q.pop_front();
      cyc(1'b0, 4'h0, 1'b1);
      check("rand_flush", {4'd0, dout}, {4'd0, exp_d});
    end
    flags("rand_done", 1'b1, 1'b0);

    // Asynchronous reset mid-operation, asserted between edges
    cyc(1'b1, 4'h6, 1'b0);
    cyc(1'b1, 4'h7, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    check("pre_rst_dout", {4'd0, dout}, 8'h6);
    #2 reset = 1'b1;
    #1;
    flags("async_rst", 1'b1, 1'b0);
    check("async_rst_dout", {4'd0, dout}, 8'h0);
    #1 reset = 1'b0;
    step();
    flags("post_rst", 1'b1, 1'b0);
    cyc(1'b1, 4'h9, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    check("post_rst_rd9", {4'd0, dout}, 8'h9);
    flags("post_rst_rd9", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
